// File: rtl/sap_program_loader.sv
// Streams program bytes from a valid/ready source into sap_ram over the W bus.
// Each byte is written as an address phase (maddr latch) followed by a data phase (RAM write).
module sap_program_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [7:0]            bus_out,
    output logic                  bus_drive,
    output logic                  maddr_latch,
    output logic                  ram_latch,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_q       <= last_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_d       = last_q;
        byte_count_d = byte_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_WAIT_BYTE;
                    addr_d       = '0;
                    byte_count_d = '0;
                end
            end
            S_WAIT_BYTE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: state_d = S_DATA;
            S_DATA: begin
                byte_count_d = byte_count_q + COUNT_ONE;
                // The top location ends the load even without in_last; the address never wraps.
                if (last_q || (addr_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_WAIT_BYTE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a decode of registered state, so in_valid never reaches an output combinationally.
    always_comb begin
        in_ready    = 1'b0;
        bus_out     = '0;
        bus_drive   = 1'b0;
        maddr_latch = 1'b0;
        ram_latch   = 1'b0;
        done        = 1'b0;
        cpu_hold    = (state_q != S_IDLE);
        busy        = (state_q != S_IDLE);
        byte_count  = byte_count_q;

        case (state_q)
            S_WAIT_BYTE: in_ready = 1'b1;
            S_ADDR: begin
                bus_drive   = 1'b1;
                bus_out     = 8'(addr_q);
                maddr_latch = 1'b1;
            end
            S_DATA: begin
                bus_drive = 1'b1;
                bus_out   = data_q;
                ram_latch = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sap_program_loader.sv
// Directed bench for sap_program_loader with a small sap_ram model on the bus side.
module tb_sap_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic       maddr_latch;
    logic       ram_latch;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [4:0] byte_count;

    int checks   = 0;
    int failures = 0;

    sap_program_loader #(.ADDR_WIDTH(4), .MEM_DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .bus_out    (bus_out),
        .bus_drive  (bus_drive),
        .maddr_latch(maddr_latch),
        .ram_latch  (ram_latch),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // sap_ram stand-in: address register loaded by maddr_latch, memory written by ram_latch.
    logic [3:0] mar;
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (reset) mar <= 4'h0;
        else begin
            if (maddr_latch) mar <= bus_out[3:0];
            if (ram_latch)   mem[mar] <= bus_out;
        end
    end

    // Bus monitor sampled mid-cycle.
    int         cyc = 0;
    int         acc_cnt = 0, mad_cnt = 0, ram_cnt = 0, done_cnt = 0, overlap_cnt = 0, stray_cnt = 0;
    int         done_cyc = 0;
    int         acc_cyc [$];
    logic [7:0] addr_log [$];
    logic [7:0] data_log [$];
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
        if (maddr_latch) begin
            mad_cnt++;
            addr_log.push_back(bus_out);
        end
        if (ram_latch) begin
            ram_cnt++;
            data_log.push_back(bus_out);
        end
        if (maddr_latch && ram_latch) overlap_cnt++;
        if (bus_drive != (maddr_latch || ram_latch)) stray_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {in_ready, bus_out, bus_drive, maddr_latch, ram_latch, cpu_hold, busy, done, byte_count};
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offers n bytes base+i; in_last on index last_at; random idle gaps up to max_gap;
    // optionally pulses start right after byte pulse_at is accepted.
    task automatic drive_bytes(input int n, input logic [7:0] base, input int last_at,
                               input int max_gap, input int pulse_at);
        int   sent = 0;
        int   budget;
        logic acc;
        while (sent < n) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = base + 8'(sent);
            in_last  = (sent == last_at);
            budget   = 0;
            acc      = 1'b0;
            while (!acc && budget < 50) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) begin
                check_eq("accept_timeout", 32'(sent), 32'(n));
                break;
            end
            sent++;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (sent == pulse_at) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input logic [4:0] exp_count);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("byte_count", 32'(byte_count), 32'(exp_count));
        check_eq("hold_in_done", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check_eq("hold_after_done", {cpu_hold, busy, done}, 32'd0);
        check_eq("count_held", 32'(byte_count), 32'(exp_count));
    endtask

    initial begin
        int a0, d0, m0, r0, k0, c0, ov0;

        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", all_outs(), 32'd0);
        @(posedge clk); #1 reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("no_ready_before_start", {in_ready, busy, cpu_hold}, 32'd0);
        check_eq("no_accept_before_start", 32'(acc_cnt), 32'd0);
        in_valid = 1'b0;

        // Full 16-byte load, in_valid held high, then a 17th byte offered.
        a0 = addr_log.size(); d0 = data_log.size(); k0 = done_cnt; c0 = acc_cyc.size();
        pulse_start();
        #1 check_eq("hold_after_start", {cpu_hold, busy, in_ready}, 32'b111);
        drive_bytes(16, 8'h10, -1, 0, -1);
        in_valid = 1'b1; in_data = 8'h20;
        wait_done(5'd16);
        repeat (6) @(negedge clk);
        check_eq("no_17th_accept", 32'(acc_cnt), 32'd16);
        in_valid = 1'b0;
        check_eq("full_addr_n", 32'(addr_log.size() - a0), 32'd16);
        check_eq("full_data_n", 32'(data_log.size() - d0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("full_addr%0d", i), 32'(addr_log[a0 + i]), 32'(i));
            check_eq($sformatf("full_data%0d", i), 32'(data_log[d0 + i]), 32'(8'h10 + i));
            check_eq($sformatf("full_mem%0d", i), 32'(mem[i]), 32'(8'h10 + i));
        end
        check_eq("full_latency", 32'(done_cyc - acc_cyc[c0]), 32'd48);
        check_eq("full_done_once", 32'(done_cnt - k0), 32'd1);

        // Early end on byte 5.
        a0 = addr_log.size(); k0 = done_cnt;
        pulse_start();
        drive_bytes(5, 8'hA0, 4, 0, -1);
        wait_done(5'd5);
        check_eq("early_addr_n", 32'(addr_log.size() - a0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("early_addr%0d", i), 32'(addr_log[a0 + i]), 32'(i));
            check_eq($sformatf("early_mem%0d", i), 32'(mem[i]), 32'(8'hA0 + i));
        end
        check_eq("early_mem5_kept", 32'(mem[5]), 32'h15);
        check_eq("early_done_once", 32'(done_cnt - k0), 32'd1);

        // Backpressure with random gaps.
        d0 = data_log.size(); m0 = mad_cnt; r0 = ram_cnt; ov0 = overlap_cnt;
        pulse_start();
        drive_bytes(10, 8'h50, 9, 4, -1);
        wait_done(5'd10);
        check_eq("bp_maddr_cnt", 32'(mad_cnt - m0), 32'd10);
        check_eq("bp_ram_cnt", 32'(ram_cnt - r0), 32'd10);
        check_eq("bp_overlap", 32'(overlap_cnt - ov0), 32'd0);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("bp_data%0d", i), 32'(data_log[d0 + i]), 32'(8'h50 + i));

        // start pulsed while busy after the third byte.
        a0 = addr_log.size();
        pulse_start();
        drive_bytes(6, 8'h30, 5, 0, 3);
        wait_done(5'd6);
        check_eq("restart_addr_n", 32'(addr_log.size() - a0), 32'd6);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("restart_addr%0d", i), 32'(addr_log[a0 + i]), 32'(i));

        // Reset during the DATA phase of byte 7, then a fresh 2-byte load.
        pulse_start();
        drive_bytes(7, 8'h70, -1, 0, -1);
        @(posedge clk); #1;
        check_eq("pre_reset_data_phase", {ram_latch, bus_out}, {1'b1, 8'h76});
        reset = 1'b1;
        #1 check_eq("midload_reset_outs", all_outs(), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        check_eq("mem5_partial", 32'(mem[5]), 32'h75);
        a0 = addr_log.size();
        pulse_start();
        drive_bytes(2, 8'hC0, 1, 0, -1);
        wait_done(5'd2);
        check_eq("post_reset_addr_n", 32'(addr_log.size() - a0), 32'd2);
        check_eq("post_reset_addr0", 32'(addr_log[a0]), 32'd0);
        check_eq("post_reset_addr1", 32'(addr_log[a0 + 1]), 32'd1);
        check_eq("post_reset_mem0", 32'(mem[0]), 32'hC0);
        check_eq("post_reset_mem1", 32'(mem[1]), 32'hC1);
        check_eq("post_reset_mem2_kept", 32'(mem[2]), 32'h72);

        check_eq("overlap_total", 32'(overlap_cnt), 32'd0);
        check_eq("bus_drive_stray", 32'(stray_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
